// File: rtl/mem_arb_pkg.sv
// Types and sizing for the memory bus arbiter.
// The arbiter top honours the MEM_ARB_ROUND_ROBIN_EN build macro.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } owner_t;

  localparam int CNT_W = 16;
endpackage

// File: rtl/pipeline_pkg.sv
// Pipeline-wide sizing shared by the core blocks.
package pipeline;
  localparam int XLEN = 32;
endpackage

// File: rtl/mem_arb_watchdog.sv
// Transaction watchdog: counts busy cycles and flags expiry at TIMEOUT_CYCLES.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [CNT_W-1:0] r_count;

  // Busy-cycle counter; holds at the limit until cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expired = (r_count == CNT_W'(TIMEOUT_CYCLES));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN           = pipeline::XLEN,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_re,
  input  logic [3:0]      i_sel,
  input  logic [XLEN-1:0] i_addr,
  output logic            i_ack,
  output logic            i_err,
  output logic [31:0]     i_instr,
  input  logic            d_re,
  input  logic            d_we,
  input  logic [3:0]      d_sel,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_ack,
  output logic            d_err,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_re,
  output logic            mem_we,
  output logic [3:0]      mem_sel,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  arb_state_t r_state;
  owner_t     r_last_owner;
  logic       w_busy;
  logic       w_expired;
  logic       w_clear;
  logic       w_i_req;
  logic       w_d_req;
  logic       w_pick_data;

  assign w_busy  = (r_state != IDLE);
  assign w_i_req = i_re;
  assign w_d_req = d_re | d_we;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign w_pick_data = w_d_req & (~w_i_req | (r_last_owner == INSTR));
`else
  assign w_pick_data = w_d_req;
`endif

  // Counter restarts whenever the bus is idle or a transaction finishes.
  assign w_clear = ~w_busy | mem_ack | w_expired;

  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (w_clear),
    .i_enable (w_busy),
    .o_expired(w_expired)
  );

  // A same-cycle mem_ack beats expiry, so err is qualified by ~mem_ack.
  assign i_ack   = (r_state == BUSY_I) & mem_ack;
  assign d_ack   = (r_state == BUSY_D) & mem_ack;
  assign i_err   = (r_state == BUSY_I) & w_expired & ~mem_ack;
  assign d_err   = (r_state == BUSY_D) & w_expired & ~mem_ack;
  assign i_instr = i_ack ? mem_rdata[31:0] : 32'd0;
  assign d_rdata = d_ack ? mem_rdata : {XLEN{1'b0}};

  // Grant FSM with registered memory-side request fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_sel   <= 4'd0;
      mem_addr  <= {XLEN{1'b0}};
      mem_wdata <= {XLEN{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_d_req || w_i_req) begin
            mem_re    <= w_pick_data ? d_re : 1'b1;
            mem_we    <= w_pick_data & d_we;
            mem_sel   <= w_pick_data ? d_sel : i_sel;
            mem_addr  <= w_pick_data ? d_addr : i_addr;
            mem_wdata <= w_pick_data ? d_wdata : {XLEN{1'b0}};
            r_state   <= w_pick_data ? BUSY_D : BUSY_I;
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ack || w_expired) begin
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_state <= r_state;
          end
        end
        default: begin
          mem_re  <= 1'b0;
          mem_we  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Remembers who completed last; drives alternation when enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_owner <= INSTR;
    end else if (w_busy && mem_ack) begin
      r_last_owner <= (r_state == BUSY_D) ? DATA : INSTR;
    end else begin
      r_last_owner <= r_last_owner;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized self-checking bench for mem_bus_arbiter (default fixed-priority build).
module tb_mem_bus_arbiter;
  localparam int XLEN = pipeline::XLEN;
  localparam int TO   = 4;

  logic            clk;
  logic            reset_n;
  logic            i_re;
  logic [3:0]      i_sel;
  logic [XLEN-1:0] i_addr;
  logic            i_ack;
  logic            i_err;
  logic [31:0]     i_instr;
  logic            d_re;
  logic            d_we;
  logic [3:0]      d_sel;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic            d_ack;
  logic            d_err;
  logic [XLEN-1:0] d_rdata;
  logic            mem_re;
  logic            mem_we;
  logic [3:0]      mem_sel;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(
    .XLEN(XLEN),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_re(i_re), .i_sel(i_sel), .i_addr(i_addr),
    .i_ack(i_ack), .i_err(i_err), .i_instr(i_instr),
    .d_re(d_re), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, ".i_ack"}, i_ack, 1'b0);
    check_eq({tag, ".i_err"}, i_err, 1'b0);
    check_eq({tag, ".d_ack"}, d_ack, 1'b0);
    check_eq({tag, ".d_err"}, d_err, 1'b0);
    check_eq({tag, ".i_instr"}, i_instr, 32'd0);
    check_eq({tag, ".d_rdata"}, d_rdata, {XLEN{1'b0}});
  endtask

  // Called from the negedge of the cycle in which the request is visible.
  // lat = busy-cycle index at which memory answers; beyond TO means no answer.
  task automatic serve(input bit is_d, input bit we, input logic [XLEN-1:0] addr,
                       input logic [3:0] sel, input logic [XLEN-1:0] wdata,
                       input int lat, input bit drop);
    logic [XLEN-1:0] rd;
    bit done;
    int j;
    done = 1'b0;
    j = 0;
    @(negedge clk);
    while (!done) begin
      rd = XLEN'($urandom);
      mem_rdata = rd;
      mem_ack = (j == lat);
      #1;
      check_eq("mem_re", mem_re, is_d ? !we : 1'b1);
      check_eq("mem_we", mem_we, is_d & we);
      check_eq("mem_addr", mem_addr, addr);
      check_eq("mem_sel", mem_sel, sel);
      if (is_d) check_eq("mem_wdata", mem_wdata, wdata);
      if (j == lat) begin
        check_eq("i_ack", i_ack, !is_d);
        check_eq("d_ack", d_ack, is_d);
        check_eq("i_err_on_ack", i_err, 1'b0);
        check_eq("d_err_on_ack", d_err, 1'b0);
        check_eq("i_instr", i_instr, is_d ? 32'd0 : rd[31:0]);
        if (!(is_d && we)) check_eq("d_rdata", d_rdata, is_d ? rd : {XLEN{1'b0}});
        done = 1'b1;
      end else if (j == TO) begin
        check_eq("i_err", i_err, !is_d);
        check_eq("d_err", d_err, is_d);
        check_eq("i_ack_on_err", i_ack, 1'b0);
        check_eq("d_ack_on_err", d_ack, 1'b0);
        done = 1'b1;
      end else begin
        check_quiet("busy");
      end
      if (drop && j == 0) begin
        if (is_d) begin d_re = 1'b0; d_we = 1'b0; end
        else i_re = 1'b0;
      end
      if (!done) begin
        @(negedge clk);
        j++;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    if (is_d) begin d_re = 1'b0; d_we = 1'b0; end
    else i_re = 1'b0;
    #1;
    check_eq("idle.mem_re", mem_re, 1'b0);
    check_eq("idle.mem_we", mem_we, 1'b0);
    check_quiet("idle");
  endtask

  initial begin
    bit has_i, has_d, dwe;
    int kind;
    logic [XLEN-1:0] ia, da, dw;
    logic [3:0] is, ds;

    reset_n = 1'b0;
    i_re = 1'b0; i_sel = 4'd0; i_addr = '0;
    d_re = 1'b0; d_we = 1'b0; d_sel = 4'd0; d_addr = '0; d_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst.mem_re", mem_re, 1'b0);
    check_eq("rst.mem_we", mem_we, 1'b0);
    check_eq("rst.mem_sel", mem_sel, 4'd0);
    check_eq("rst.mem_addr", mem_addr, {XLEN{1'b0}});
    check_eq("rst.mem_wdata", mem_wdata, {XLEN{1'b0}});
    check_quiet("rst");
    reset_n = 1'b1;

    // Single fetch answered two cycles after the strobe rises.
    @(negedge clk);
    i_re = 1'b1; i_addr = XLEN'(32'h100); i_sel = 4'hF;
    serve(1'b0, 1'b0, XLEN'(32'h100), 4'hF, '0, 2, 1'b0);

    // Store held until ack.
    d_we = 1'b1; d_sel = 4'b0011; d_addr = XLEN'(32'h40); d_wdata = XLEN'(32'hDEADBEEF);
    serve(1'b1, 1'b1, XLEN'(32'h40), 4'b0011, XLEN'(32'hDEADBEEF), 3, 1'b0);

    // Data read that times out, then a normal fetch.
    d_re = 1'b1; d_sel = 4'hF; d_addr = XLEN'(32'h80);
    serve(1'b1, 1'b0, XLEN'(32'h80), 4'hF, XLEN'(32'hDEADBEEF), TO + 2, 1'b0);
    i_re = 1'b1; i_addr = XLEN'(32'h104);
    serve(1'b0, 1'b0, XLEN'(32'h104), 4'hF, '0, TO, 1'b0);

    // Stray ack while idle is ignored.
    mem_ack = 1'b1;
    #1 check_quiet("stray");
    @(negedge clk);
    mem_ack = 1'b0;
    #1 check_eq("stray.mem_re", mem_re, 1'b0);

    // Random traffic: fixed priority serves data first, instruction next.
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 3);
      has_i = (kind == 0) || (kind == 3);
      has_d = (kind != 0);
      dwe = has_d && ($urandom_range(0, 1) == 1);
      ia = XLEN'($urandom); da = XLEN'($urandom); dw = XLEN'($urandom);
      is = 4'($urandom); ds = 4'($urandom);
      @(negedge clk);
      i_re = has_i; i_addr = ia; i_sel = is;
      d_re = has_d && !dwe; d_we = dwe; d_addr = da; d_sel = ds; d_wdata = dw;
      if (has_d) serve(1'b1, dwe, da, ds, dw, $urandom_range(0, TO + 2), $urandom_range(0, 1) == 1);
      if (has_i) serve(1'b0, 1'b0, ia, is, '0, $urandom_range(0, TO + 2), $urandom_range(0, 1) == 1);
    end

    // Async reset mid-fetch abandons it.
    @(negedge clk);
    i_re = 1'b1; i_addr = XLEN'(32'h200); i_sel = 4'hF;
    @(negedge clk);
    #1 check_eq("pre_rst.mem_re", mem_re, 1'b1);
    #1 reset_n = 1'b0;
    #1 check_eq("async_rst.mem_re", mem_re, 1'b0);
    i_re = 1'b0;
    mem_ack = 1'b1;
    #1 check_quiet("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    #1 check_quiet("post_rst");
    @(negedge clk);
    mem_ack = 1'b0;
    #1 check_eq("post_rst.mem_re", mem_re, 1'b0);
    check_quiet("post_rst_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external memory port between the instruction-fetch requester and the load/store requester.
- Registered grant FSM: one outstanding transaction at a time, forwarded on registered memory-side outputs.
- The response is routed back to the owning requester.
- A watchdog terminates stalled transactions with an error, so the IFU or LSU never hangs.

Parameters:
- XLEN, pipeline::XLEN, address/data width.
- TIMEOUT_CYCLES, 255, cycles to wait for mem_ack before aborting with error; must be ≥ 1 and fit in 16 bits.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- i_re  in  1  instruction read request; level, held until i_ack or i_err.
- i_sel  in  4  instruction byte lanes.
- i_addr  in  XLEN  instruction address.
- i_ack  out  1  instruction transaction done; i_instr valid this cycle.
- i_err  out  1  instruction transaction timed out.
- i_instr  out  32  fetched word.
- d_re  in  1  data read request; level.
- d_we  in  1  data write request; level; d_re and d_we never both high.
- d_sel  in  4  data byte lanes.
- d_addr  in  XLEN  data address.
- d_wdata  in  XLEN  store data.
- d_ack  out  1  data transaction done; d_rdata valid this cycle for reads.
- d_err  out  1  data transaction timed out.
- d_rdata  out  XLEN  load data.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_sel  out  4  memory byte lanes.
- mem_addr  out  XLEN  memory address.
- mem_wdata  out  XLEN  memory write data.
- mem_ack  in  1  memory completion, single cycle.
- mem_rdata  in  XLEN  memory read data, valid with mem_ack.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - mem_re, mem_we, mem_sel, mem_addr, mem_wdata = 0.
  - Timeout counter = 0; last_owner = INSTR.
  - All ack/err outputs 0.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - Samples i_re and d_re|d_we at posedge.
  - Winner's request fields are latched into the mem_* registers; state moves to BUSY_I or BUSY_D.
  - The mem strobe is therefore high from the cycle after the request is first seen (1-cycle issue latency).
- Default priority: data over instruction when both request in the same cycle.
- BUSY_x:
  - mem_* held stable; counter increments each cycle.
  - When mem_ack=1:
    - Combinationally assert x_ack.
    - Route mem_rdata to i_instr (low 32 bits) or d_rdata.
    - At posedge: clear the strobes, reset the counter, set last_owner=x, go to IDLE.
- Per-transaction latency: request-to-ack is 1 + memory latency cycles. A requester may re-request in the cycle after ack; it is sampled there (one IDLE bubble between transactions).
- Timeout: if the counter reaches TIMEOUT_CYCLES without mem_ack:
  - Assert x_err for 1 cycle (x_ack stays 0).
  - Clear the strobes and go to IDLE.
  - A mem_ack in the same cycle as expiry wins: ack, no err.
- Non-owner's ack/err are always 0. i_instr/d_rdata read 0 when their ack is low.
- Stray mem_ack in IDLE is ignored.
- A requester dropping its request mid-transaction does not abort; the transaction completes and the ack is still pulsed.
- A reset mid-transaction abandons it; no ack/err after release.

Optional Feature:
- MEM_ARB_ROUND_ROBIN_EN defined: on a simultaneous request, the grant goes to the requester that is not last_owner (alternation).
- Undefined: fixed data-over-instruction priority; last_owner still tracked but unused for arbitration.

Decomposition:
- Package mem_arb_pkg: typedef enum arb_state_t {IDLE, BUSY_I, BUSY_D}; typedef enum owner_t {INSTR, DATA}; localparam for counter width.
- XLEN taken from pipeline.
- Sub-module mem_arb_watchdog: counter with clear/enable inputs, expired output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Single fetch: i_re=1, i_addr=0x100, mem_ack 2 cycles after mem_re rises with mem_rdata=0x00500093 -> mem_re high in cycle+1; i_ack pulse with i_instr=0x00500093; d_ack=0.
- Simultaneous requests (macro off): i_re and d_re both rise at cycle 0, each serviced -> data served first (mem_addr=d_addr); instruction granted on the IDLE cycle after d_ack.
- Round robin (macro on): last_owner=DATA, both request -> instruction granted first; the next contention grants data.
- Store: d_we=1, d_sel=0b0011, d_wdata=0xDEADBEEF -> mem_we=1 with identical sel/wdata held stable until mem_ack; d_ack pulses; mem_re never asserted.
- Timeout: TIMEOUT_CYCLES=4, d_re=1, no mem_ack -> d_err pulses 4 cycles after grant; strobes drop; a following i_re is served normally.
- Async reset while BUSY_I -> mem_re drops immediately without clock; no i_ack after release; a later late mem_ack in IDLE is ignored.
